// File: rtl/user_arbiter_wrr_pkg.sv
// Shared request types and derived length constants, plus the arbiter helpers
// that depend only on them.
package lynxTypes;
  localparam int AXI_DATA_BITS = 512;
  localparam int LEN_BITS      = 28;
  localparam int VADDR_BITS    = 48;
  localparam int PID_BITS      = 6;
  localparam int DEST_BITS     = 4;
  localparam int N_OUTSTANDING = 8;
  localparam int BEAT_LOG_BITS = $clog2(AXI_DATA_BITS / 8);
  localparam int BLEN_BITS     = LEN_BITS - BEAT_LOG_BITS;

  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
    logic [PID_BITS-1:0]   pid;
    logic [DEST_BITS-1:0]  dest;
    logic                  strm;
    logic                  last;
  } req_t;
endpackage

package user_arbiter_wrr_pkg;
  import lynxTypes::*;

  typedef enum int unsigned {
    ARB_RR  = 0,
    ARB_WRR = 1
  } arb_mode_e;

  // Beats minus one; a zero length maps to zero instead of wrapping.
  function automatic logic [BLEN_BITS-1:0] calc_n_tr(input logic [LEN_BITS-1:0] len);
    return (len == '0) ? '0 : BLEN_BITS'((len - 1'b1) >> BEAT_LOG_BITS);
  endfunction
endpackage

// File: rtl/meta_intf.sv
// Valid/ready metadata channel carrying one STYPE word per handshake.
interface metaIntf #(
  parameter type STYPE = logic [63:0]
);
  logic valid;
  logic ready;
  STYPE data;

  modport s (input valid, input data, output ready);
  modport m (output valid, output data, input ready);
endinterface

// File: rtl/user_arbiter_wrr_queue_meta.sv
// Metadata FIFO holding the arbiter's {id, n_tr} sequence in grant order.
// Full is reported as s_meta.ready low; empty as m_meta.valid low.
module queue_meta #(
  parameter int  QDEPTH = 8,
  parameter type STYPE  = logic [63:0]
) (
  input logic aclk,
  input logic aresetn,
  metaIntf.s  s_meta,
  metaIntf.m  m_meta
);
  localparam int PTR_BITS = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_BITS = $clog2(QDEPTH + 1);

  STYPE                mem_q [QDEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                push, pop;

  function automatic logic [PTR_BITS-1:0] wrap_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign s_meta.ready = (count_q != CNT_BITS'(QDEPTH));
  assign m_meta.valid = (count_q != '0);
  assign m_meta.data  = mem_q[rd_ptr_q];
  assign push         = s_meta.valid && s_meta.ready;
  assign pop          = m_meta.valid && m_meta.ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q gates visibility, so stale words are never observed.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_meta.data;
  end
endmodule

// File: rtl/user_arbiter_wrr.sv
// Weighted round-robin arbiter: N_CPID request channels onto one registered
// output, with an in-order {id, n_tr} sequence queue for the data-path demux.
module user_arbiter_wrr
  import lynxTypes::*;
  import user_arbiter_wrr_pkg::*;
#(
  parameter int N_CPID      = 2,
  parameter int QDEPTH      = N_OUTSTANDING,
  parameter int WEIGHT_BITS = 4,
  parameter int MODE        = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  metaIntf.s                            s_meta [N_CPID],
  metaIntf.m                            m_meta,
  metaIntf.m                            mux,
  input  logic [N_CPID*WEIGHT_BITS-1:0] weights,
  output logic                          seq_full
);
  localparam int N_CPID_BITS = $clog2(N_CPID);
  localparam int MUX_BITS    = N_CPID_BITS + BLEN_BITS;

  typedef logic [MUX_BITS-1:0]    mux_t;
  typedef logic [N_CPID_BITS-1:0] cpid_t;
  typedef logic [WEIGHT_BITS-1:0] weight_t;

  logic [N_CPID-1:0]  req_valid;
  req_t               req_data [N_CPID];
  weight_t            w_eff    [N_CPID];

  cpid_t              ptr_q, ptr_d;
  weight_t            cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  req_t               out_data_q, out_data_d;

  cpid_t              grant;
  logic               any_valid;
  logic               acc;
  logic [WEIGHT_BITS:0] k;

  metaIntf #(.STYPE(mux_t)) seq_in ();

  for (genvar i = 0; i < N_CPID; i++) begin : g_src
    weight_t w_raw;
    assign w_raw          = weights[i*WEIGHT_BITS +: WEIGHT_BITS];
    assign w_eff[i]       = (arb_mode_e'(MODE) == ARB_RR || w_raw == '0) ? weight_t'(1) : w_raw;
    assign req_valid[i]   = s_meta[i].valid;
    assign req_data[i]    = s_meta[i].data;
    assign s_meta[i].ready = acc && (grant == cpid_t'(i));
  end

  // Scan from the far end back toward ptr so the nearest valid channel wins last.
  always_comb begin
    int    idx;
    cpid_t cand;
    grant     = ptr_q;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int off = N_CPID - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_CPID) idx = idx - N_CPID;
      cand = cpid_t'(idx);
      if (req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Holding acc low under reset keeps every upstream ready deasserted.
  assign acc = aresetn && any_valid && (!out_valid_q || m_meta.ready) && seq_in.ready;

  assign seq_in.valid = acc;
  assign seq_in.data  = {grant, calc_n_tr(req_data[grant].len)};
  assign seq_full     = !seq_in.ready;

  assign m_meta.valid = out_valid_q;
  assign m_meta.data  = out_data_q;

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    k           = '0;
    if (acc) begin
      // The burst count only continues while the pointer channel keeps winning.
      k = (grant == ptr_q) ? {1'b0, cnt_q} + 1'b1 : (WEIGHT_BITS+1)'(1);
      if (k >= {1'b0, w_eff[grant]}) begin
        ptr_d = (grant == cpid_t'(N_CPID - 1)) ? '0 : grant + 1'b1;
        cnt_d = '0;
      end else begin
        ptr_d = grant;
        cnt_d = k[WEIGHT_BITS-1:0];
      end
      out_valid_d = 1'b1;
      out_data_d  = req_data[grant];
    end else if (m_meta.ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge aclk) begin
    out_data_q <= out_data_d;
  end

  queue_meta #(
    .QDEPTH (QDEPTH),
    .STYPE  (mux_t)
  ) inst_seq_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_meta  (seq_in),
    .m_meta  (mux)
  );
endmodule

// File: tb/tb_user_arbiter_wrr.sv
// Bench for user_arbiter_wrr: directed grant-order scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_user_arbiter_wrr;
  import lynxTypes::*;

  localparam int N    = 4;
  localparam int QD   = 4;
  localparam int WB   = 4;
  localparam int IDB  = $clog2(N);
  localparam int MUXB = IDB + BLEN_BITS;
  typedef logic [MUXB-1:0] mux_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  metaIntf #(.STYPE(req_t)) s_meta [N] ();
  metaIntf #(.STYPE(req_t)) m_meta ();
  metaIntf #(.STYPE(mux_t)) mux ();
  logic [N*WB-1:0] weights;
  logic            seq_full;

  logic [N-1:0] src_valid;
  req_t         src_data [N];
  logic [N-1:0] obs_rdy;
  logic         m_ready, mux_ready;
  logic [N-1:0] gate;

  for (genvar i = 0; i < N; i++) begin : g_tb_src
    assign s_meta[i].valid = src_valid[i];
    assign s_meta[i].data  = src_data[i];
    assign obs_rdy[i]      = s_meta[i].ready;
  end
  assign m_meta.ready = m_ready;
  assign mux.ready    = mux_ready;

  user_arbiter_wrr #(
    .N_CPID(N), .QDEPTH(QD), .WEIGHT_BITS(WB), .MODE(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_meta(s_meta), .m_meta(m_meta),
    .mux(mux), .weights(weights), .seq_full(seq_full)
  );

  // Upstream sources: one pending-request queue per channel.
  req_t src_q [N][$];

  // Reference model state.
  typedef struct { int id; int ntr; } seq_ent_t;
  int       mdl_ptr, mdl_cnt;
  bit       mdl_out_valid;
  req_t     mdl_out_data;
  seq_ent_t mdl_seq [$];
  int       mdl_w [N];
  int       exp_g;
  bit       exp_acc;

  // Per-tick snapshot of expectation and observation.
  logic [N-1:0] exp_rdy_s, obs_rdy_s;
  bit           exp_m_valid_s, exp_mux_valid_s, exp_full_s;
  req_t         exp_m_data_s;
  seq_ent_t     exp_mux_s;
  logic         obs_m_valid, obs_mux_valid, obs_full;
  req_t         obs_m_data;
  mux_t         obs_mux_data;
  int           obs_g;

  int   grant_log [$];
  req_t out_log [$];
  mux_t mux_log [$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int ref_ntr(input longint len);
    if (len == 0) return 0;
    return int'(((len - 1) / (AXI_DATA_BITS / 8)) % (longint'(1) << BLEN_BITS));
  endfunction

  function automatic req_t new_req(input int ch, input int len);
    req_t r;
    r.vaddr = VADDR_BITS'({$urandom(), $urandom()});
    r.len   = LEN_BITS'(len);
    r.pid   = PID_BITS'(ch);
    r.dest  = DEST_BITS'($urandom_range(0, 15));
    r.strm  = 1'($urandom_range(0, 1));
    r.last  = 1'b1;
    return r;
  endfunction

  task automatic load(input int ch, input int n);
    for (int j = 0; j < n; j++) src_q[ch].push_back(new_req(ch, $urandom_range(1, 8192)));
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    int w [N];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < N; i++) begin
      weights[i*WB +: WB] = WB'(w[i]);
      mdl_w[i] = (w[i] == 0) ? 1 : w[i];
    end
  endtask

  function automatic void model_expect();
    exp_g = -1;
    for (int off = 0; off < N; off++) begin
      int c;
      c = (mdl_ptr + off) % N;
      if (src_valid[c]) begin
        exp_g = c;
        break;
      end
    end
    exp_acc = (exp_g >= 0) && (!mdl_out_valid || m_ready) && (mdl_seq.size() < QD);
  endfunction

  task automatic model_commit();
    bit pop;
    pop = mux_ready && (mdl_seq.size() > 0);
    if (pop) void'(mdl_seq.pop_front());
    if (exp_acc) begin
      int kk;
      seq_ent_t e;
      kk = (exp_g == mdl_ptr) ? mdl_cnt + 1 : 1;
      if (kk >= mdl_w[exp_g]) begin
        mdl_ptr = (exp_g + 1) % N;
        mdl_cnt = 0;
      end else begin
        mdl_ptr = exp_g;
        mdl_cnt = kk;
      end
      e.id  = exp_g;
      e.ntr = ref_ntr(longint'(src_data[exp_g].len));
      mdl_seq.push_back(e);
      mdl_out_valid = 1'b1;
      mdl_out_data  = src_data[exp_g];
    end else if (m_ready) begin
      mdl_out_valid = 1'b0;
    end
  endtask

  // One clock cycle: present sources, sample everything mid-cycle, commit at the edge.
  task automatic tick();
    for (int i = 0; i < N; i++) begin
      src_valid[i] = gate[i] && (src_q[i].size() > 0);
      src_data[i]  = '0;
      if (src_q[i].size() > 0) src_data[i] = src_q[i][0];
    end
    #1;
    model_expect();
    exp_rdy_s       = exp_acc ? N'(1 << exp_g) : '0;
    exp_m_valid_s   = mdl_out_valid;
    exp_m_data_s    = mdl_out_data;
    exp_mux_valid_s = (mdl_seq.size() > 0);
    exp_mux_s       = '{-1, -1};
    if (mdl_seq.size() > 0) exp_mux_s = mdl_seq[0];
    exp_full_s      = (mdl_seq.size() == QD);
    obs_rdy_s     = obs_rdy;
    obs_m_valid   = m_meta.valid;
    obs_m_data    = m_meta.data;
    obs_mux_valid = mux.valid;
    obs_mux_data  = mux.data;
    obs_full      = seq_full;
    obs_g = -1;
    for (int i = 0; i < N; i++)
      if (src_valid[i] && obs_rdy[i]) obs_g = (obs_g == -1) ? i : 99;
    grant_log.push_back(obs_g);
    if (obs_m_valid && m_ready) out_log.push_back(obs_m_data);
    if (obs_mux_valid && mux_ready) mux_log.push_back(obs_mux_data);
    @(posedge aclk);
    if (obs_g >= 0 && obs_g < N) void'(src_q[obs_g].pop_front());
    model_commit();
    @(negedge aclk);
  endtask

  task automatic model_reset();
    mdl_ptr = 0;
    mdl_cnt = 0;
    mdl_out_valid = 1'b0;
    mdl_seq.delete();
    grant_log.delete();
    out_log.delete();
    mux_log.delete();
  endtask

  task automatic apply_reset();
    aresetn   = 1'b0;
    gate      = '1;
    m_ready   = 1'b1;
    mux_ready = 1'b1;
    src_valid = '0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    aresetn   = 1'b0;
    m_ready   = 1'b1;
    mux_ready = 1'b1;
    set_weights(1, 1, 1, 1);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      src_data[i] = new_req(i, 64);
    end
    src_valid = '1;
    repeat (2) @(negedge aclk);
    #1;
    n_checks++;
    if (obs_rdy !== '0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", obs_rdy); end
    n_checks++;
    if (m_meta.valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_meta.valid); end
    n_checks++;
    if (mux.valid !== 1'b0) begin n_fail++; $display("FAIL reset_mux_valid: got %b expected 0", mux.valid); end
    n_checks++;
    if (seq_full !== 1'b0) begin n_fail++; $display("FAIL reset_seq_full: got %b expected 0", seq_full); end
    @(negedge aclk);
    src_valid = '0;
    apply_reset();
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_weights(0, 1, 0, 1);
    for (int i = 0; i < N; i++) load(i, 10);
    repeat (9) tick();
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (grant_log[j] !== j % N) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", j, grant_log[j], j % N); end
    end
    n_checks++;
    if (out_log.size() != 8) begin n_fail++; $display("FAIL rr_outputs: got %0d expected 8", out_log.size()); end
    for (int j = 0; j < out_log.size() && j < 8; j++) begin
      n_checks++;
      if (int'(out_log[j].pid) !== j % N) begin n_fail++; $display("FAIL rr_out_pid[%0d]: got %0d expected %0d", j, out_log[j].pid, j % N); end
    end
  endtask

  task automatic test_weighted();
    int exp_order [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    apply_reset();
    set_weights(3, 1, 5, 5);
    load(0, 10);
    load(1, 10);
    repeat (8) tick();
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (grant_log[j] !== exp_order[j]) begin n_fail++; $display("FAIL wrr_order[%0d]: got %0d expected %0d", j, grant_log[j], exp_order[j]); end
    end
  endtask

  task automatic test_skip_idle();
    apply_reset();
    set_weights(1, 1, 1, 1);
    load(1, 6);
    load(3, 6);
    repeat (6) tick();
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (grant_log[j] !== ((j % 2 == 0) ? 1 : 3)) begin n_fail++; $display("FAIL skip_order[%0d]: got %0d expected %0d", j, grant_log[j], (j % 2 == 0) ? 1 : 3); end
    end
  endtask

  task automatic test_backpressure();
    req_t first;
    int   exp_after [4] = '{1, 2, 3, 0};
    apply_reset();
    set_weights(1, 1, 1, 1);
    for (int i = 0; i < N; i++) load(i, 6);
    first   = src_q[0][0];
    m_ready = 1'b0;
    tick();
    for (int j = 1; j < 5; j++) begin
      tick();
      n_checks++;
      if (obs_m_valid !== 1'b1 || obs_m_data !== first) begin
        n_fail++;
        $display("FAIL hold_data[%0d]: got valid=%b vaddr=%h expected valid=1 vaddr=%h", j, obs_m_valid, obs_m_data.vaddr, first.vaddr);
      end
    end
    n_checks++;
    if (grant_log.sum() with (int'(item >= 0)) != 1) begin n_fail++; $display("FAIL hold_accepts: got %0d expected 1", grant_log.sum() with (int'(item >= 0))); end
    m_ready = 1'b1;
    repeat (4) tick();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (grant_log[5 + j] !== exp_after[j]) begin n_fail++; $display("FAIL resume_order[%0d]: got %0d expected %0d", j, grant_log[5 + j], exp_after[j]); end
    end
    n_checks++;
    if (out_log.size() < 1 || out_log[0] !== first) begin n_fail++; $display("FAIL resume_first: got %0d outputs, expected held request first", out_log.size()); end
  endtask

  task automatic test_n_tr();
    int lens [N] = '{64, 65, 4096, 0};
    int ntrs [N] = '{0, 1, 63, 0};
    apply_reset();
    set_weights(1, 1, 1, 1);
    for (int i = 0; i < N; i++) src_q[i].push_back(new_req(i, lens[i]));
    repeat (6) tick();
    n_checks++;
    if (mux_log.size() != N || out_log.size() != N) begin
      n_fail++;
      $display("FAIL ntr_count: got mux=%0d out=%0d expected %0d", mux_log.size(), out_log.size(), N);
    end else begin
      for (int j = 0; j < N; j++) begin
        n_checks++;
        if (int'(mux_log[j][BLEN_BITS-1:0]) !== ntrs[j]) begin n_fail++; $display("FAIL ntr_value[%0d]: got %0d expected %0d", j, mux_log[j][BLEN_BITS-1:0], ntrs[j]); end
        n_checks++;
        if (int'(mux_log[j][BLEN_BITS +: IDB]) !== int'(out_log[j].pid)) begin n_fail++; $display("FAIL ntr_id[%0d]: got %0d expected %0d", j, mux_log[j][BLEN_BITS +: IDB], out_log[j].pid); end
      end
    end
  endtask

  task automatic test_seq_full();
    int accepts;
    apply_reset();
    set_weights(1, 1, 1, 1);
    for (int i = 0; i < N; i++) load(i, 6);
    mux_ready = 1'b0;
    repeat (7) tick();
    accepts = grant_log.sum() with (int'(item >= 0));
    n_checks++;
    if (accepts != QD) begin n_fail++; $display("FAIL full_accepts: got %0d expected %0d", accepts, QD); end
    n_checks++;
    if (obs_full !== 1'b1 || obs_rdy_s !== '0) begin n_fail++; $display("FAIL full_stall: got full=%b ready=%b expected full=1 ready=0000", obs_full, obs_rdy_s); end
    n_checks++;
    if (obs_m_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain: got m_valid=%b expected 0", obs_m_valid); end
    mux_ready = 1'b1;
    tick();
    n_checks++;
    if (obs_rdy_s !== '0) begin n_fail++; $display("FAIL full_pop_cycle: got ready=%b expected 0000", obs_rdy_s); end
    mux_ready = 1'b0;
    grant_log.delete();
    repeat (3) tick();
    accepts = grant_log.sum() with (int'(item >= 0));
    n_checks++;
    if (accepts != 1 || grant_log[0] !== 0) begin n_fail++; $display("FAIL full_one_more: got %0d accepts first=%0d expected 1 accept of channel 0", accepts, grant_log[0]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_weights(1, 1, 1, 1);
    for (int i = 0; i < N; i++) load(i, 4);
    m_ready   = 1'b0;
    mux_ready = 1'b0;
    repeat (2) tick();
    aresetn = 1'b0;
    @(negedge aclk);
    #1;
    n_checks++;
    if (m_meta.valid !== 1'b0 || mux.valid !== 1'b0 || seq_full !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got m_valid=%b mux_valid=%b full=%b expected 0 0 0", m_meta.valid, mux.valid, seq_full);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int special [5] = '{0, 1, 64, 65, 4096};
    apply_reset();
    set_weights($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 150; j++)
        src_q[i].push_back(new_req(i, ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom_range(0, 1 << 20)));
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) gate[i] = ($urandom_range(0, 3) != 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      mux_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (obs_rdy_s !== exp_rdy_s) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, obs_rdy_s, exp_rdy_s); end
      n_checks++;
      if (obs_m_valid !== exp_m_valid_s || (exp_m_valid_s && obs_m_data !== exp_m_data_s)) begin
        n_fail++;
        $display("FAIL rnd_m_meta@%0d: got valid=%b vaddr=%h expected valid=%b vaddr=%h", c, obs_m_valid, obs_m_data.vaddr, exp_m_valid_s, exp_m_data_s.vaddr);
      end
      n_checks++;
      if (obs_mux_valid !== exp_mux_valid_s ||
          (exp_mux_valid_s && (int'(obs_mux_data[BLEN_BITS +: IDB]) != exp_mux_s.id || int'(obs_mux_data[BLEN_BITS-1:0]) != exp_mux_s.ntr))) begin
        n_fail++;
        $display("FAIL rnd_mux@%0d: got valid=%b id=%0d ntr=%0d expected valid=%b id=%0d ntr=%0d", c, obs_mux_valid,
                 obs_mux_data[BLEN_BITS +: IDB], obs_mux_data[BLEN_BITS-1:0], exp_mux_valid_s, exp_mux_s.id, exp_mux_s.ntr);
      end
      n_checks++;
      if (obs_full !== exp_full_s) begin n_fail++; $display("FAIL rnd_full@%0d: got %b expected %b", c, obs_full, exp_full_s); end
    end
  endtask

  initial begin
    aresetn   = 1'b0;
    src_valid = '0;
    gate      = '1;
    m_ready   = 1'b1;
    mux_ready = 1'b1;
    weights   = '0;
    for (int i = 0; i < N; i++) src_data[i] = '0;
    @(negedge aclk);
    test_reset();
    test_round_robin();
    test_weighted();
    test_skip_idle();
    test_backpressure();
    test_n_tr();
    test_seq_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
